// File: rtl/proc_boot_loader.sv
// proc_boot_loader: streams a length-prefixed, checksummed program image from a
// host port into IMem, holds the Proc core in reset while loading, then
// releases it and supervises the run (halt -> DONE, run-cycle limit -> ERR).
module proc_boot_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_LEN   = 10,
    parameter int IMEM_DEPTH = 1024,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    output logic                imem_we,
    output logic [ADDR_LEN-1:0] imem_addr,
    output logic [WIDTH-1:0]    imem_wdata,
    output logic                core_rst_n,
    input  logic                halt,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [CNT_W-1:0]    cycle_cnt
);

    // Remaining-word counter must hold IMEM_DEPTH itself, hence the +1.
    localparam int                REM_W   = $clog2(IMEM_DEPTH + 1);
    localparam logic [WIDTH-1:0]  DEPTH_W = WIDTH'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;
    localparam logic [1:0] ERR_TIME = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_CHK, S_RUN, S_DONE, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [REM_W-1:0]     rem_q;
    logic [ADDR_LEN-1:0]  addr_q;
    logic [WIDTH-1:0]     sum_q;
    logic [CNT_W-1:0]     cycle_cnt_q;
    logic [1:0]           err_code_q;
    logic                 imem_we_q;
    logic [ADDR_LEN-1:0]  imem_addr_q;
    logic [WIDTH-1:0]     imem_wdata_q;

    logic accept;
    logic can_start;
    logic hdr_bad;
    logic last_word;
    logic chk_ok;
    logic timeout;

    assign accept    = in_valid & in_ready;
    assign can_start = start & (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign hdr_bad   = (in_data == '0) || (in_data > DEPTH_W);
    assign last_word = (rem_q == REM_W'(1));
    assign chk_ok    = (in_data == sum_q);
    assign timeout   = (cycle_cnt_q == MAX_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; halt has priority over the run-cycle limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (can_start) state_d = S_HDR;
            S_HDR:  if (accept) state_d = hdr_bad ? S_ERR : S_LOAD;
            S_LOAD: if (accept && last_word) state_d = S_CHK;
            S_CHK:  if (accept) state_d = chk_ok ? S_RUN : S_ERR;
            S_RUN: begin
                if (halt)         state_d = S_DONE;
                else if (timeout) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status and handshake outputs decoded from the registered state.
    always_comb begin
        in_ready   = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
        busy       = in_ready || (state_q == S_RUN);
        done       = (state_q == S_DONE);
        err        = (state_q == S_ERR);
        // The core stays out of reset after DONE so its state can be inspected.
        core_rst_n = (state_q == S_RUN) || (state_q == S_DONE);
    end

    // Datapath: header/length tracking, IMem write pipeline, checksum, run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q        <= '0;
            addr_q       <= '0;
            sum_q        <= '0;
            cycle_cnt_q  <= '0;
            err_code_q   <= ERR_NONE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (can_start) begin
                        cycle_cnt_q <= '0;
                        err_code_q  <= ERR_NONE;
                        sum_q       <= '0;
                        addr_q      <= '0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            err_code_q <= ERR_LEN;
                        end else begin
                            // Bounds check above guarantees the length fits REM_W bits.
                            rem_q  <= in_data[REM_W-1:0];
                            addr_q <= '0;
                            sum_q  <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= addr_q;
                        imem_wdata_q <= in_data;
                        sum_q        <= sum_q + in_data;
                        addr_q       <= addr_q + 1'b1;
                        rem_q        <= rem_q - 1'b1;
                    end
                end
                S_CHK: begin
                    if (accept && !chk_ok) err_code_q <= ERR_SUM;
                end
                S_RUN: begin
                    if (!halt) begin
                        if (timeout) err_code_q  <= ERR_TIME;
                        else         cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign err_code   = err_code_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_proc_boot_loader.sv
// Testbench for proc_boot_loader: scenario tasks with inline checks against an
// image-level reference (expected write list, additive checksum, run length).
module tb_proc_boot_loader;

    localparam int WIDTH      = 32;
    localparam int ADDR_LEN   = 4;
    localparam int IMEM_DEPTH = 16;
    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 80;

    logic                clk;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic                in_ready;
    logic                imem_we;
    logic [ADDR_LEN-1:0] imem_addr;
    logic [WIDTH-1:0]    imem_wdata;
    logic                core_rst_n;
    logic                halt;
    logic                busy;
    logic                done;
    logic                err;
    logic [1:0]          err_code;
    logic [CNT_W-1:0]    cycle_cnt;

    proc_boot_loader #(
        .WIDTH(WIDTH), .ADDR_LEN(ADDR_LEN), .IMEM_DEPTH(IMEM_DEPTH),
        .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .halt(halt),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                  cyc;
        logic [ADDR_LEN-1:0] addr;
        logic [WIDTH-1:0]    data;
    } wr_t;

    wr_t              wr_log[$];
    wr_t              exp_wr[$];
    logic [WIDTH-1:0] img[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    // Log every IMem write pulse with the cycle in which it was visible.
    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            e.cyc  = cyc;
            e.addr = imem_addr;
            e.data = imem_wdata;
            wr_log.push_back(e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference checksum: additive sum of the image modulo 2**WIDTH.
    function automatic logic [WIDTH-1:0] img_sum();
        longint unsigned acc = 0;
        foreach (img[i]) acc = (acc + longint'(img[i])) % (64'd1 << WIDTH);
        return acc[WIDTH-1:0];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Offer one word after 'gap' idle cycles; returns the cycle it was accepted.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap, output int acc_cyc);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL send_word in_ready got %0b want 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        wr_log.delete();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0)   $display("FAIL reset in_ready got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (core_rst_n !== 1'b0) $display("FAIL reset core_rst_n got %0b want 0", core_rst_n); else n_pass++;
        n_checks++; if (busy !== 1'b0)       $display("FAIL reset busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0)       $display("FAIL reset done got %0b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0)        $display("FAIL reset err got %0b want 0", err); else n_pass++;
        n_checks++; if (err_code !== 2'd0)   $display("FAIL reset err_code got %0d want 0", err_code); else n_pass++;
        n_checks++; if (cycle_cnt !== '0)    $display("FAIL reset cycle_cnt got %0d want 0", cycle_cnt); else n_pass++;
        n_checks++; if (imem_we !== 1'b0)    $display("FAIL reset imem_we got %0b want 0", imem_we); else n_pass++;
        // Host words and halt while idle must be ignored.
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            halt     = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        halt     = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL idle_ignore flags got busy=%0b done=%0b err=%0b want 0/0/0", busy, done, err); else n_pass++;
        n_checks++; if (wr_log.size() != 0) $display("FAIL idle_ignore writes got %0d want 0", wr_log.size()); else n_pass++;
    endtask

    task automatic test_bad_len();
        logic [WIDTH-1:0] hdrs[3];
        int c;
        hdrs[0] = '0;
        hdrs[1] = WIDTH'(IMEM_DEPTH + 1);
        hdrs[2] = WIDTH'(IMEM_DEPTH + 2) + WIDTH'($urandom_range(0, 100000));
        for (int i = 0; i < 3; i++) begin
            wr_log.delete();
            do_start();
            send_word(hdrs[i], 0, c);
            @(negedge clk);
            n_checks++; if (err !== 1'b1)        $display("FAIL bad_len[%0d] err got %0b want 1", i, err); else n_pass++;
            n_checks++; if (err_code !== 2'd1)   $display("FAIL bad_len[%0d] err_code got %0d want 1", i, err_code); else n_pass++;
            n_checks++; if (core_rst_n !== 1'b0) $display("FAIL bad_len[%0d] core_rst_n got %0b want 0", i, core_rst_n); else n_pass++;
            n_checks++; if (in_ready !== 1'b0)   $display("FAIL bad_len[%0d] in_ready got %0b want 0", i, in_ready); else n_pass++;
            n_checks++; if (wr_log.size() != 0)  $display("FAIL bad_len[%0d] writes got %0d want 0", i, wr_log.size()); else n_pass++;
        end
    endtask

    // Load img with the given checksum word; expectations derived from the image.
    task automatic test_image(input string name, input int gapmax, input logic [WIDTH-1:0] chk);
        int               c;
        bit               ok;
        wr_t              e;
        wr_log.delete();
        exp_wr.delete();
        do_start();
        send_word(WIDTH'(img.size()), 0, c);
        for (int i = 0; i < img.size(); i++) begin
            send_word(img[i], $urandom_range(0, gapmax), c);
            e.cyc  = c;
            e.addr = ADDR_LEN'(i);
            e.data = img[i];
            exp_wr.push_back(e);
        end
        send_word(chk, $urandom_range(0, gapmax), c);
        ok = (chk == img_sum());
        @(negedge clk);
        n_checks++; if (busy !== ok)             $display("FAIL %s busy got %0b want %0b", name, busy, ok); else n_pass++;
        n_checks++; if (err !== !ok)             $display("FAIL %s err got %0b want %0b", name, err, !ok); else n_pass++;
        n_checks++; if (core_rst_n !== ok)       $display("FAIL %s core_rst_n got %0b want %0b", name, core_rst_n, ok); else n_pass++;
        n_checks++; if (err_code !== (ok ? 2'd0 : 2'd2))
            $display("FAIL %s err_code got %0d want %0d", name, err_code, ok ? 0 : 2); else n_pass++;
        n_checks++; if (cycle_cnt !== '0)        $display("FAIL %s cycle_cnt got %0d want 0", name, cycle_cnt); else n_pass++;
        n_checks++; if (wr_log.size() != exp_wr.size())
            $display("FAIL %s write_count got %0d want %0d", name, wr_log.size(), exp_wr.size()); else n_pass++;
        foreach (exp_wr[i]) begin
            if (i < wr_log.size()) begin
                n_checks++;
                if (wr_log[i].cyc !== exp_wr[i].cyc || wr_log[i].addr !== exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data)
                    $display("FAIL %s write[%0d] got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             name, i, wr_log[i].cyc, wr_log[i].addr, wr_log[i].data,
                             exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
                else n_pass++;
            end
        end
    endtask

    // From the first RUN cycle, let the core run k cycles, then raise halt.
    task automatic test_halt(input string name, input int k);
        repeat (k) @(posedge clk);
        #1 halt = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1)        $display("FAIL %s done got %0b want 1", name, done); else n_pass++;
        n_checks++; if (busy !== 1'b0)        $display("FAIL %s busy got %0b want 0", name, busy); else n_pass++;
        n_checks++; if (cycle_cnt !== CNT_W'(k)) $display("FAIL %s cycle_cnt got %0d want %0d", name, cycle_cnt, k); else n_pass++;
        n_checks++; if (core_rst_n !== 1'b1)  $display("FAIL %s core_rst_n got %0b want 1", name, core_rst_n); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            halt = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        halt = 1'b0;
        n_checks++; if (cycle_cnt !== CNT_W'(k) || done !== 1'b1)
            $display("FAIL %s frozen got cnt=%0d done=%0b want cnt=%0d done=1", name, cycle_cnt, done, k); else n_pass++;
    endtask

    task automatic test_load_ok();
        img = '{32'h1, 32'h2, 32'h3};
        test_image("load_ok", 0, 32'h6);
        test_halt("halt50", 50);
    endtask

    task automatic test_bad_chk();
        img = '{32'h1, 32'h2, 32'h3};
        test_image("bad_chk", 1, 32'h7);
    endtask

    task automatic test_timeout();
        int k = 0;
        img = '{32'h1, 32'h2, 32'h3};
        test_image("to_load", 1, 32'h6);
        // A start pulse while running must be ignored.
        while (err !== 1'b1 && k < MAX_CYCLES + 20) begin
            @(posedge clk);
            #1;
            k++;
            start = (k == 5);
        end
        start = 1'b0;
        n_checks++; if (k != MAX_CYCLES + 1)   $display("FAIL timeout latency got %0d want %0d", k, MAX_CYCLES + 1); else n_pass++;
        n_checks++; if (err_code !== 2'd3)     $display("FAIL timeout err_code got %0d want 3", err_code); else n_pass++;
        n_checks++; if (cycle_cnt !== CNT_W'(MAX_CYCLES))
            $display("FAIL timeout cycle_cnt got %0d want %0d", cycle_cnt, MAX_CYCLES); else n_pass++;
        n_checks++; if (core_rst_n !== 1'b0)   $display("FAIL timeout core_rst_n got %0b want 0", core_rst_n); else n_pass++;
        do_start();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0)
            $display("FAIL restart flags got busy=%0b rdy=%0b err=%0b want 1/1/0", busy, in_ready, err); else n_pass++;
        n_checks++; if (err_code !== 2'd0 || cycle_cnt !== '0)
            $display("FAIL restart clear got err_code=%0d cnt=%0d want 0/0", err_code, cycle_cnt); else n_pass++;
        n_checks++; if (core_rst_n !== 1'b0)   $display("FAIL restart core_rst_n got %0b want 0", core_rst_n); else n_pass++;
    endtask

    task automatic test_rst_mid_load();
        int  c;
        wr_t e;
        apply_reset();
        wr_log.delete();
        exp_wr.delete();
        do_start();
        send_word(WIDTH'(5), 0, c);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) do_start();
            e.data = $urandom;
            send_word(e.data, 2, c);
            e.cyc  = c;
            e.addr = ADDR_LEN'(i);
            exp_wr.push_back(e);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_mid flags got busy=%0b rdy=%0b want 0/0", busy, in_ready); else n_pass++;
        n_checks++; if (core_rst_n !== 1'b0 || imem_we !== 1'b0)
            $display("FAIL rst_mid outs got core_rst_n=%0b we=%0b want 0/0", core_rst_n, imem_we); else n_pass++;
        n_checks++; if (wr_log.size() != exp_wr.size())
            $display("FAIL rst_mid write_count got %0d want %0d", wr_log.size(), exp_wr.size()); else n_pass++;
        foreach (exp_wr[i]) begin
            if (i < wr_log.size()) begin
                n_checks++;
                if (wr_log[i].cyc !== exp_wr[i].cyc || wr_log[i].addr !== exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data)
                    $display("FAIL rst_mid write[%0d] got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             i, wr_log[i].cyc, wr_log[i].addr, wr_log[i].data,
                             exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int               n;
        int               k;
        logic [WIDTH-1:0] chk;
        logic [WIDTH-1:0] one;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? IMEM_DEPTH : $urandom_range(1, IMEM_DEPTH);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            one = 1;
            chk = img_sum();
            if (it > 1 && $urandom_range(0, 2) == 0) chk = chk ^ (one << $urandom_range(0, WIDTH - 1));
            test_image($sformatf("rand%0d", it), 2, chk);
            if (chk == img_sum()) begin
                // it==1: halt coincides with the cycle limit; halt must win.
                k = (it == 1) ? MAX_CYCLES : $urandom_range(0, MAX_CYCLES);
                test_halt($sformatf("rand%0d_halt", it), k);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        halt     = 1'b0;
        test_reset();
        test_bad_len();
        test_load_ok();
        test_bad_chk();
        test_timeout();
        test_rst_mid_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
